// File: rtl/sti_deserializer.sv
// ----------------------------------------------------------------------------
// sti_deserializer
// Receive side of the STI serial link. Samples the si_data/si_valid bit stream
// and rebuilds each 8/16/24/32-bit frame. The 16-bit payload is then extracted
// from the frame according to the latched configuration. Any nonzero pad bits
// are flagged. A frame is dropped when the gap between its bits is too long.
//
// Ports
//   clk, reset            clock (rising edge) / async active-low reset
//   cfg_load              latch cfg_* (honoured only while idle)
//   cfg_length[1:0]       frame width W: 00=8, 01=16, 10=24, 11=32
//   cfg_msb               1: first bit received is F[W-1], 0: first is F[0]
//   cfg_fill              24/32b: 1 = payload in top 16 bits of F
//   cfg_low               8b: 1 = byte goes to po_data[15:8]
//   si_data, si_valid     serial bit and its strobe
//   po_data[15:0]         reassembled word, held until the next frame
//   po_valid              1-cycle pulse, po_data/po_err valid
//   po_err                pad bits nonzero (qualified by po_valid)
//   po_abort              1-cycle pulse, frame dropped on gap timeout
//   busy                  1 while receiving a frame
//   frame_cnt[CNT_W-1:0]  number of po_valid pulses, wrapping
// ----------------------------------------------------------------------------
module sti_deserializer #(
    parameter int GAP_MAX = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [1:0]       cfg_length,
    input  logic             cfg_msb,
    input  logic             cfg_fill,
    input  logic             cfg_low,
    input  logic             si_data,
    input  logic             si_valid,
    output logic [15:0]      po_data,
    output logic             po_valid,
    output logic             po_err,
    output logic             po_abort,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int GAP_W = $clog2(GAP_MAX + 2);

    typedef enum logic [1:0] {IDLE, RECV, EMIT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         len_q, len_d;
    logic               msb_q, msb_d, fill_q, fill_d, low_q, low_d;
    logic [31:0]        f_q, f_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [15:0]        data_q, data_d;
    logic               valid_q, valid_d, err_q, err_d, abort_q, abort_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;

    logic [31:0]        f_shift;
    logic               last_bit;
    logic [15:0]        ext_data;
    logic               ext_err;

    always_comb begin
        // Frame register with the current bit merged in (RECV only).
        f_shift  = msb_q ? {f_q[30:0], si_data} : (f_q | ({31'b0, si_data} << cnt_q));
        // W-1 is {len,3'b111} for every supported width.
        last_bit = (cnt_q == {len_q, 3'b111});

        ext_data = f_shift[15:0];
        ext_err  = 1'b0;
        case (len_q)
            2'b00: ext_data = low_q ? {f_shift[7:0], 8'h00} : {8'h00, f_shift[7:0]};
            2'b01: ext_data = f_shift[15:0];
            2'b10: begin
                ext_data = fill_q ? f_shift[23:8] : f_shift[15:0];
                ext_err  = fill_q ? |f_shift[7:0] : |f_shift[23:16];
            end
            default: begin
                ext_data = fill_q ? f_shift[31:16] : f_shift[15:0];
                ext_err  = fill_q ? |f_shift[15:0] : |f_shift[31:16];
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        msb_d   = msb_q;
        fill_d  = fill_q;
        low_d   = low_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        data_d  = data_q;
        fcnt_d  = fcnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        abort_d = 1'b0;

        // Config only changes between frames; a load coincident with the
        // first bit applies to that frame, since the first bit always lands in
        // F[0] and the later bits see the new registers.
        if (state_q == IDLE && cfg_load) begin
            len_d  = cfg_length;
            msb_d  = cfg_msb;
            fill_d = cfg_fill;
            low_d  = cfg_low;
        end

        case (state_q)
            RECV: begin
                if (si_valid) begin
                    gap_d = '0;
                    f_d   = f_shift;
                    cnt_d = cnt_q + 5'd1;
                    if (last_bit) begin
                        state_d = EMIT;
                        cnt_d   = '0;
                        data_d  = ext_data;
                        err_d   = ext_err;
                        valid_d = 1'b1;
                        fcnt_d  = fcnt_q + 1'b1;
                    end
                end else if (gap_q == GAP_W'(GAP_MAX)) begin
                    // This idle cycle would be gap number GAP_MAX+1.
                    state_d = IDLE;
                    abort_d = 1'b1;
                    gap_d   = '0;
                    cnt_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin  // IDLE and EMIT: a strobe starts a new frame
                if (si_valid) begin
                    state_d = RECV;
                    f_d     = {31'b0, si_data};
                    cnt_d   = 5'd1;
                    gap_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            msb_q   <= 1'b0;
            fill_q  <= 1'b0;
            low_q   <= 1'b0;
            f_q     <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            msb_q   <= msb_d;
            fill_q  <= fill_d;
            low_q   <= low_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign po_data   = data_q;
    assign po_valid  = valid_q;
    assign po_err    = err_q;
    assign po_abort  = abort_q;
    assign busy      = (state_q == RECV);
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_sti_deserializer.sv
module tb_sti_deserializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_load = 1'b0;
    logic [1:0]  cfg_length = 2'b00;
    logic        cfg_msb = 1'b0, cfg_fill = 1'b0, cfg_low = 1'b0;
    logic        si_data = 1'b0, si_valid = 1'b0;
    logic [15:0] po_data;
    logic        po_valid, po_err, po_abort, busy;
    logic [7:0]  frame_cnt;

    sti_deserializer #(.GAP_MAX(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_length(cfg_length),
        .cfg_msb(cfg_msb), .cfg_fill(cfg_fill), .cfg_low(cfg_low),
        .si_data(si_data), .si_valid(si_valid), .po_data(po_data),
        .po_valid(po_valid), .po_err(po_err), .po_abort(po_abort),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [15:0] data;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0, n_fail = 0, n_abort = 0;
    logic [7:0] m_cnt = '0;
    logic [1:0] m_len = '0;
    logic       m_fill = 1'b0, m_low = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Payload/pad extraction as a function of the whole frame F.
    function automatic logic [16:0] model(input logic [31:0] f, input logic [1:0] len,
                                          input logic fill, input logic low);
        case (len)
            2'b00:   return {1'b0, low ? {f[7:0], 8'h00} : {8'h00, f[7:0]}};
            2'b01:   return {1'b0, f[15:0]};
            2'b10:   return fill ? {|f[7:0], f[23:8]} : {|f[23:16], f[15:0]};
            default: return fill ? {|f[15:0], f[31:16]} : {|f[31:16], f[15:0]};
        endcase
    endfunction

    task automatic push(input logic [31:0] f);
        logic [16:0] r;
        r = model(f, m_len, m_fill, m_low);
        m_cnt++;
        sb.push_back('{err: r[16], data: r[15:0], cnt: m_cnt});
    endtask

    // Scoreboard consumer: every po_valid pulse must match the oldest entry.
    always @(negedge clk) begin
        exp_t e;
        if (po_abort) n_abort++;
        if (po_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_po_valid", 32'(po_data), 32'hDEAD_0000);
            end else begin
                e = sb.pop_front();
                chk("po_data", 32'(po_data), 32'(e.data));
                chk("po_err", 32'(po_err), 32'(e.err));
                chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic load_cfg(input logic [1:0] len, input logic msb, input logic fill, input logic low);
        @(posedge clk); #1;
        cfg_length = len; cfg_msb = msb; cfg_fill = fill; cfg_low = low; cfg_load = 1'b1;
        m_len = len; m_fill = fill; m_low = low;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    // Sends w bits of f; optional idle gap before bit gap_at, optional
    // cfg_load pulse alongside bit load_at.
    task automatic send(input logic [31:0] f, input int w, input logic msb,
                        input int gap_at, input int gap_len, input int load_at);
        for (int k = 0; k < w; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                    si_valid = 1'b0; cfg_load = 1'b0;
                end
            end
            @(posedge clk); #1;
            si_valid = 1'b1;
            si_data  = msb ? f[w-1-k] : f[k];
            cfg_load = (k == load_at);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        si_valid = 1'b0; si_data = 1'b0; cfg_load = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 64) begin
            @(posedge clk); t++;
        end
        #1;
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_po_data", 32'(po_data), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_po_valid", 32'(po_valid), 0);
        #20 reset = 1'b1;

        // 1: 16b MSB-first
        load_cfg(2'b01, 1'b1, 1'b0, 1'b0);
        push(32'h0000_A5C3);
        send(32'h0000_A5C3, 16, 1'b1, -1, 0, -1);
        chk("busy_in_recv", 32'(busy), 1);
        idle(4);
        drain("drain_t1");

        // 2: 8b LSB-first into the high byte
        load_cfg(2'b00, 1'b0, 1'b0, 1'b1);
        push(32'h0000_003C);
        send(32'h0000_003C, 8, 1'b0, -1, 0, -1);
        idle(4);
        drain("drain_t2");

        // 3: 32b, payload low, clean pad then a set pad bit
        load_cfg(2'b11, 1'b1, 1'b0, 1'b0);
        push(32'h0000_1234);
        send(32'h0000_1234, 32, 1'b1, -1, 0, -1);
        idle(3);
        push(32'h8000_1234);
        send(32'h8000_1234, 32, 1'b1, -1, 0, -1);
        idle(4);
        drain("drain_t3");

        // 4: 24b LSB-first, payload high; tolerated gap then fatal gap
        load_cfg(2'b10, 1'b0, 1'b1, 1'b0);
        push(32'h00BE_EF00);
        send(32'h00BE_EF00, 24, 1'b0, 12, 3, -1);
        idle(4);
        drain("drain_t4");
        chk("no_abort_gap3", 32'(n_abort), 0);
        send(32'h0000_02A5, 10, 1'b0, -1, 0, -1);
        idle(8);
        chk("abort_gap5", 32'(n_abort), 1);
        chk("busy_after_abort", 32'(busy), 0);
        chk("cnt_after_abort", 32'(frame_cnt), 32'(m_cnt));

        // 5: back-to-back 16b frames, cfg_load in RECV/EMIT is ignored
        load_cfg(2'b01, 1'b1, 1'b0, 1'b0);
        cfg_length = 2'b00; cfg_msb = 1'b0; cfg_fill = 1'b1; cfg_low = 1'b1;
        push(32'h0000_1357);
        push(32'h0000_FACE);
        send(32'h0000_1357, 16, 1'b1, -1, 0, 5);
        send(32'h0000_FACE, 16, 1'b1, -1, 0, 0);
        idle(4);
        drain("drain_t5");
        chk("frame_cnt_plus2", 32'(frame_cnt), 32'd7);

        // 6: async reset mid-frame, then a clean frame
        load_cfg(2'b01, 1'b0, 1'b0, 1'b0);
        send(32'h0000_03FF, 10, 1'b0, -1, 0, -1);
        chk("busy_mid_frame", 32'(busy), 1);
        #2 reset = 1'b0; si_valid = 1'b0;
        #1;
        chk("arst_po_data", 32'(po_data), 0);
        chk("arst_frame_cnt", 32'(frame_cnt), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_flags", 32'({po_valid, po_err, po_abort}), 0);
        m_cnt = '0;
        @(posedge clk); #1 reset = 1'b1;
        load_cfg(2'b01, 1'b0, 1'b0, 1'b0);
        push(32'h0000_8421);
        send(32'h0000_8421, 16, 1'b0, -1, 0, -1);
        idle(4);
        drain("drain_t6");
        chk("frame_cnt_after_rst", 32'(frame_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
